ecc_scrub_ctrl: RTL and testbench

- Background memory scrubber for a codeword RAM protected by Hamming(7,4)+overall-parity SECDED.
- Walks every address, feeds each stored codeword to an external hamming_secded decoder, and writes back re-encoded data on correctable errors.
- Counts and flags uncorrectable errors.
- Shares the RAM port with a host; the host always has priority.

---
 rtl/ecc_scrub_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_ecc_scrub_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_scrub_ctrl.sv
// Background SECDED scrubber: sweeps a Hamming(7,4)+parity codeword RAM, writes back corrected
// words, counts correctable/uncorrectable errors. The host port always has priority.
module ecc_scrub_ctrl #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_scrub_en,
  input  logic              i_start,
  input  logic [15:0]       i_interval,
  input  logic              i_host_req,
  input  logic              i_host_we,
  input  logic [ADDR_W-1:0] i_host_addr,
  output logic              o_mem_re,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_wdata,
  input  logic [7:0]        i_mem_rdata,
  output logic [7:0]        o_dec_codeword,
  input  logic [3:0]        i_dec_data,
  input  logic              i_dec_1bit,
  input  logic              i_dec_2bit,
  input  logic              i_dec_parity,
  output logic              o_busy,
  output logic              o_done,
  output logic [CNT_W-1:0]  o_corr_cnt,
  output logic [CNT_W-1:0]  o_uncorr_cnt,
  output logic [ADDR_W-1:0] o_last_uncorr_addr,
  output logic              o_uncorr_irq,
  input  logic              i_irq_clr
);

  typedef enum logic [2:0] {StIdle, StWait, StRead, StCheck, StWrite} state_e;

  state_e            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_timer;
  logic [7:0]        r_wdata;
  logic [7:0]        r_codeword;
  logic              r_cancel;
  logic [CNT_W-1:0]  r_corr_cnt;
  logic [CNT_W-1:0]  r_uncorr_cnt;
  logic [ADDR_W-1:0] r_last_uncorr;
  logic              r_irq;
  logic              r_done;

  logic              w_last;
  logic              w_snoop;
  logic              w_fix;
  logic              w_write_go;
  logic              w_adv;
  logic              w_sweep_end;
  state_e            w_after_sweep;

  // Bits 6:0 = {d3,d2,d1,p4,d0,p2,p1}, bit 7 = even parity over 6:0.
  function automatic logic [7:0] f_encode(input logic [3:0] d);
    logic [6:0] c;
    c = {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
    return {^c, c};
  endfunction

  assign w_last        = (r_addr == ADDR_W'(DEPTH - 1));
  assign w_snoop       = i_host_we && (i_host_addr == r_addr);
  assign w_fix         = i_dec_1bit || i_dec_parity;
  assign w_write_go    = (r_state == StWrite) && !i_host_req;
  assign w_adv         = ((r_state == StCheck) && (i_dec_2bit || !w_fix)) || w_write_go;
  assign w_sweep_end   = w_adv && w_last;
  assign w_after_sweep = i_scrub_en ? StWait : StIdle;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_nxt = StRead;
        end else if (i_scrub_en) begin
          w_state_nxt = StWait;
        end
      end
      StWait: begin
        if (i_start) begin
          w_state_nxt = StRead;
        end else if (!i_scrub_en) begin
          w_state_nxt = StIdle;
        end else if (r_timer == 16'd0) begin
          w_state_nxt = StRead;
        end
      end
      StRead: begin
        if (!i_host_req) begin
          w_state_nxt = StCheck;
        end
      end
      StCheck: begin
        if (!i_dec_2bit && w_fix) begin
          w_state_nxt = StWrite;
        end else begin
          w_state_nxt = w_last ? w_after_sweep : StRead;
        end
      end
      StWrite: begin
        if (!i_host_req) begin
          w_state_nxt = w_last ? w_after_sweep : StRead;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    o_mem_re = 1'b0;
    o_mem_we = 1'b0;
    o_busy   = 1'b0;
    unique case (r_state)
      StRead: begin
        o_busy   = 1'b1;
        o_mem_re = !i_host_req;
      end
      StCheck: o_busy = 1'b1;
      StWrite: begin
        o_busy   = 1'b1;
        o_mem_we = !i_host_req && !r_cancel && !w_snoop;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr        <= '0;
      r_timer       <= 16'd0;
      r_wdata       <= 8'd0;
      r_codeword    <= 8'd0;
      r_cancel      <= 1'b0;
      r_corr_cnt    <= '0;
      r_uncorr_cnt  <= '0;
      r_last_uncorr <= '0;
      r_irq         <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_done <= w_sweep_end;

      if ((r_state == StIdle) || (r_state == StWait)) begin
        r_addr <= '0;
      end else if (w_adv && !w_last) begin
        r_addr <= r_addr + 1'b1;
      end

      // Reload whenever WAIT may be entered next: from IDLE or at sweep end.
      if ((r_state == StIdle) || w_sweep_end) begin
        r_timer <= i_interval;
      end else if ((r_state == StWait) && (r_timer != 16'd0)) begin
        r_timer <= r_timer - 16'd1;
      end

      if (r_state == StCheck) begin
        r_codeword <= i_mem_rdata;
        r_wdata    <= f_encode(i_dec_data);
        r_cancel   <= w_snoop;
      end else if (r_state == StWrite) begin
        r_cancel <= r_cancel || w_snoop;
      end

      if ((r_state == StCheck) && i_dec_2bit) begin
        if (r_uncorr_cnt != '1) begin
          r_uncorr_cnt <= r_uncorr_cnt + 1'b1;
        end
        r_last_uncorr <= r_addr;
      end else if ((r_state == StCheck) && w_fix) begin
        if (r_corr_cnt != '1) begin
          r_corr_cnt <= r_corr_cnt + 1'b1;
        end
      end

      if ((r_state == StCheck) && i_dec_2bit) begin
        r_irq <= 1'b1;
      end else if (i_irq_clr) begin
        r_irq <= 1'b0;
      end
    end
  end

  // Read data arrives during CHECK; pass it straight through then, hold the copy afterwards.
  assign o_dec_codeword     = (r_state == StCheck) ? i_mem_rdata : r_codeword;
  assign o_mem_addr         = r_addr;
  assign o_mem_wdata        = r_wdata;
  assign o_done             = r_done;
  assign o_corr_cnt         = r_corr_cnt;
  assign o_uncorr_cnt       = r_uncorr_cnt;
  assign o_last_uncorr_addr = r_last_uncorr;
  assign o_uncorr_irq       = r_irq;

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Directed bench for ecc_scrub_ctrl: RAM and SECDED decoder models, vector table of error
// injections, plus host-stall, snoop-cancel and reset-during-write sequences.
module tb_ecc_scrub_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       scrub_en, start, host_req, host_we, irq_clr;
  logic [15:0] interval;
  logic [3:0] host_addr;
  logic       mem_re, mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata, dec_codeword;
  logic [3:0] dec_data;
  logic       dec_1bit, dec_2bit, dec_parity;
  logic       busy, done, uncorr_irq;
  logic [7:0] corr_cnt, uncorr_cnt;
  logic [3:0] last_uncorr_addr;

  always #5 clk = ~clk;

  ecc_scrub_ctrl #(.DEPTH(16), .ADDR_W(4), .CNT_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_scrub_en(scrub_en), .i_start(start), .i_interval(interval),
    .i_host_req(host_req), .i_host_we(host_we), .i_host_addr(host_addr),
    .o_mem_re(mem_re), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .o_dec_codeword(dec_codeword), .i_dec_data(dec_data),
    .i_dec_1bit(dec_1bit), .i_dec_2bit(dec_2bit), .i_dec_parity(dec_parity),
    .o_busy(busy), .o_done(done), .o_corr_cnt(corr_cnt), .o_uncorr_cnt(uncorr_cnt),
    .o_last_uncorr_addr(last_uncorr_addr), .o_uncorr_irq(uncorr_irq), .i_irq_clr(irq_clr)
  );

  function automatic logic [7:0] enc(input logic [3:0] d);
    logic [7:0] c;
    c[0] = d[0] ^ d[1] ^ d[3];
    c[1] = d[0] ^ d[2] ^ d[3];
    c[2] = d[0];
    c[3] = d[1] ^ d[2] ^ d[3];
    c[4] = d[1];
    c[5] = d[2];
    c[6] = d[3];
    c[7] = ^c[6:0];
    return c;
  endfunction

  // RAM model: synchronous read, scrubber and host writes, bulk load.
  logic [7:0] mem [16];
  logic [7:0] init_mem [16];
  logic       load = 1'b0;
  always @(posedge clk) begin
    if (load) begin
      mem <= init_mem;
    end else begin
      if (mem_re) mem_rdata <= mem[mem_addr];
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (host_req && host_we) mem[host_addr] <= enc(host_addr ^ 4'hF);
    end
  end

  // Decoder model; force1 additionally raises the 1-bit flag on double errors.
  logic force1 = 1'b0;
  always_comb begin
    logic [2:0] syn;
    logic [7:0] cc;
    logic       ov;
    cc  = dec_codeword;
    syn = {cc[3] ^ cc[4] ^ cc[5] ^ cc[6], cc[1] ^ cc[2] ^ cc[5] ^ cc[6],
           cc[0] ^ cc[2] ^ cc[4] ^ cc[6]};
    ov  = ^cc;
    dec_1bit = 1'b0;
    dec_2bit = 1'b0;
    dec_parity = 1'b0;
    if (syn != 3'd0 && ov) begin
      dec_1bit = 1'b1;
      cc[int'(syn) - 1] = ~cc[int'(syn) - 1];
    end else if (syn != 3'd0) begin
      dec_2bit = 1'b1;
      dec_1bit = force1;
    end else if (ov) begin
      dec_parity = 1'b1;
    end
    dec_data = {cc[6], cc[5], cc[4], cc[2]};
  end

  int cyc = 0;
  int reads, writes, viol;
  logic [3:0] last_waddr;
  logic [7:0] last_wdata;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (mem_re) reads++;
    if (mem_we) begin
      writes++;
      last_waddr = mem_addr;
      last_wdata = mem_wdata;
    end
    if ((mem_re && mem_we) || ((mem_re || mem_we) && host_req)) viol++;
  end

  int checks = 0;
  int errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_mem(input logic [3:0] fa, input logic [7:0] mask);
    for (int a = 0; a < 16; a++) begin
      init_mem[a] = enc(4'(a) ^ 4'hF) ^ ((4'(a) == fa) ? mask : 8'h00);
    end
    @(posedge clk); #1 load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
  endtask

  task automatic run_sweep(output int dur);
    int s;
    dur = -1;
    reads = 0;
    writes = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    s = cyc;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        dur = cyc - s;
        break;
      end
    end
  endtask

  typedef struct {
    logic [3:0] addr;
    logic [7:0] flip;
    bit         f1;
    int         dur;
    int         wr;
    logic [7:0] wdata;
    int         corr;
    int         uncorr;
    bit         irq;
    logic [3:0] last;
  } vec_t;

  vec_t vt [6];
  int   d;

  initial begin
    vt[0] = '{4'd0,  8'h00, 1'b0, 32, 0, 8'h00, 0, 0, 1'b0, 4'd0};
    vt[1] = '{4'd5,  8'h04, 1'b0, 33, 1, 8'hD2, 1, 0, 1'b0, 4'd0};
    vt[2] = '{4'd9,  8'h03, 1'b1, 32, 0, 8'h00, 1, 1, 1'b1, 4'd9};
    vt[3] = '{4'd12, 8'h80, 1'b0, 33, 1, 8'h1E, 2, 1, 1'b1, 4'd9};
    vt[4] = '{4'd0,  8'h40, 1'b0, 33, 1, 8'hFF, 3, 1, 1'b1, 4'd9};
    vt[5] = '{4'd15, 8'h01, 1'b0, 33, 1, 8'h00, 4, 1, 1'b1, 4'd9};

    rst = 1'b1; scrub_en = 1'b0; start = 1'b0; interval = 16'd0; host_req = 1'b0;
    host_we = 1'b0; host_addr = 4'd0; irq_clr = 1'b0; viol = 0; mem_rdata = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_re_we", {mem_re, mem_we}, 0);
    chk("rst_cnts", {corr_cnt, uncorr_cnt}, 0);
    chk("rst_irq_last", {uncorr_irq, last_uncorr_addr}, 0);
    chk("rst_addr", mem_addr, 0);
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      force1 = vt[v].f1;
      load_mem(vt[v].addr, vt[v].flip);
      run_sweep(d);
      chk($sformatf("v%0d_dur", v), d, vt[v].dur);
      chk($sformatf("v%0d_reads", v), reads, 16);
      chk($sformatf("v%0d_writes", v), writes, vt[v].wr);
      if (vt[v].wr != 0) begin
        chk($sformatf("v%0d_waddr", v), last_waddr, vt[v].addr);
        chk($sformatf("v%0d_wdata", v), last_wdata, vt[v].wdata);
      end
      chk($sformatf("v%0d_corr", v), corr_cnt, vt[v].corr);
      chk($sformatf("v%0d_uncorr", v), uncorr_cnt, vt[v].uncorr);
      chk($sformatf("v%0d_irq", v), uncorr_irq, vt[v].irq);
      chk($sformatf("v%0d_last", v), last_uncorr_addr, vt[v].last);
      force1 = 1'b0;
    end

    @(posedge clk); #1 irq_clr = 1'b1;
    @(posedge clk); #1 irq_clr = 1'b0;
    chk("irq_clr", uncorr_irq, 0);

    // Host holds the port for 3 cycles while READ sits at address 2.
    load_mem(4'd0, 8'h00);
    fork
      run_sweep(d);
      begin
        for (int i = 0; i < 200; i++) begin
          @(negedge clk);
          if (mem_re && mem_addr == 4'd1) break;
        end
        @(posedge clk); #1;
        @(posedge clk); #1 host_req = 1'b1;
        repeat (3) @(posedge clk);
        #1 host_req = 1'b0;
      end
    join
    chk("stall_dur", d, 35);
    chk("stall_reads", reads, 16);
    chk("stall_writes", writes, 0);

    // Correctable error at 7; host writes address 7 during the WRITE stall.
    load_mem(4'd7, 8'h02);
    fork
      run_sweep(d);
      begin
        for (int i = 0; i < 200; i++) begin
          @(negedge clk);
          if (mem_re && mem_addr == 4'd7) break;
        end
        @(posedge clk); #1;
        @(posedge clk); #1 host_req = 1'b1; host_we = 1'b1; host_addr = 4'd7;
        @(posedge clk); #1 host_req = 1'b0; host_we = 1'b0;
      end
    join
    chk("snoop_dur", d, 34);
    chk("snoop_writes", writes, 0);
    chk("snoop_corr", corr_cnt, 5);
    chk("snoop_mem7", mem[7], enc(4'd7 ^ 4'hF));

    // Reset while the scrubber write is on the bus, then periodic restart.
    load_mem(4'd3, 8'h02);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    d = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mem_we) begin
        d = 1;
        break;
      end
    end
    chk("rw_saw_write", d, 1);
    rst = 1'b1;
    #1;
    chk("rw_we_low", mem_we, 0);
    chk("rw_busy", busy, 0);
    chk("rw_cnts", {corr_cnt, uncorr_cnt}, 0);
    scrub_en = 1'b1;
    interval = 16'd10;
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    chk("rw_mem3_kept", mem[3], enc(4'd3 ^ 4'hF) ^ 8'h02);
    d = cyc;
    begin
      int first = -1;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (mem_re) begin
          first = cyc;
          break;
        end
      end
      chk("restart_delay", first - (d + 1), 11);
      chk("restart_addr", mem_addr, 0);
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) break;
    end
    scrub_en = 1'b0;
    chk("restart_corr", corr_cnt, 1);
    chk("restart_mem3", mem[3], enc(4'd3 ^ 4'hF));
    chk("bus_rules", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
